// File: rtl/router_pg_ctrl_pkg.sv
// Shared definitions for the router power-gating controller: FSM encoding,
// port count and the wake-request helper.
package router_pg_ctrl_pkg;

  localparam int unsigned PgCounterSize = 8;
  localparam int unsigned NumPorts      = 4;

  typedef enum logic [1:0] {
    PgActive = 2'd0,
    PgDrain  = 2'd1,
    PgSleep  = 2'd2,
    PgWake   = 2'd3
  } pgState_e;

  // Any local injection or neighbour wake request pulls the router back up.
  function automatic logic wakeReq(input logic injectReq, input logic [NumPorts-1:0] inWU);
    return injectReq | (|inWU);
  endfunction

endpackage

// File: rtl/pg_wake_req.sv
// Per-direction wake request toward a gated neighbour: set while a route needs
// that neighbour, cleared once the neighbour reports it is powered again.
module pg_wake_req (
  input  logic clk,
  input  logic reset,
  input  logic routeWant,
  input  logic inPG,
  output logic outWU
);

  logic wuQ, wuD;

  // Set wins over clear when both hold in the same cycle.
  always_comb begin
    wuD = wuQ;
    if (routeWant & inPG) begin
      wuD = 1'b1;
    end else if (!inPG) begin
      wuD = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wuQ <= 1'b0;
    end else begin
      wuQ <= wuD;
    end
  end

  assign outWU = wuQ;

endmodule

// File: rtl/router_pg_ctrl.sv
// Power-gating controller for one bufferless router: idle detection, drain,
// sleep and timed wake-up, plus wake requests toward gated neighbours.
module router_pg_ctrl
  import router_pg_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_THRESH = 16,
  parameter int unsigned DRAIN_CYC   = 3,
  parameter int unsigned WAKE_LAT    = 4,
  parameter int unsigned CNT_W       = PgCounterSize
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       inValid,
  input  logic             injectReq,
  input  logic [3:0]       inPG,
  input  logic [3:0]       inWU,
  input  logic [3:0]       routeWant,
  output logic [3:0]       outPG,
  output logic [3:0]       outWU,
  output logic             gateEn,
  output logic             isoEn,
  output logic             injectStall,
  output logic [CNT_W-1:0] pgCountValue
);

  localparam logic [CNT_W-1:0] IdleLast  = CNT_W'(IDLE_THRESH - 1);
  localparam logic [CNT_W-1:0] DrainLast = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] WakeLast  = CNT_W'(WAKE_LAT - 1);

  pgState_e         stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD, cntInc;
  logic             wake, busy;
  logic             pgQ, pgD, gateQ, gateD, isoQ, isoD, stallQ, stallD;

  assign wake   = wakeReq(injectReq, inWU);
  assign busy   = wake | (|inValid);
  assign cntInc = (&cntQ) ? cntQ : cntQ + 1'b1;

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      PgActive: begin
        if (busy) begin
          cntD = '0;
        end else if (cntQ == IdleLast) begin
          stateD = PgDrain;
          cntD   = '0;
        end else begin
          cntD = cntInc;
        end
      end
      PgDrain: begin
        if (wake) begin
          stateD = PgActive;
          cntD   = '0;
        end else if (|inValid) begin
          cntD = '0;
        end else if (cntQ == DrainLast) begin
          stateD = PgSleep;
          cntD   = '0;
        end else begin
          cntD = cntInc;
        end
      end
      PgSleep: begin
        cntD = '0;
        if (wake) begin
          stateD = PgWake;
        end
      end
      PgWake: begin
        if (cntQ == WakeLast) begin
          stateD = PgActive;
          cntD   = '0;
        end else begin
          cntD = cntInc;
        end
      end
      default: begin
        stateD = PgActive;
        cntD   = '0;
      end
    endcase
  end

  // Outputs are decoded from the current state and registered, so they trail it by a cycle.
  always_comb begin
    pgD    = 1'b0;
    gateD  = 1'b0;
    isoD   = 1'b0;
    stallD = 1'b0;
    unique case (stateQ)
      PgActive: ;
      PgDrain: begin
        pgD    = 1'b1;
        stallD = 1'b1;
      end
      PgSleep: begin
        pgD    = 1'b1;
        gateD  = 1'b1;
        isoD   = 1'b1;
        stallD = 1'b1;
      end
      PgWake: begin
        pgD    = 1'b1;
        isoD   = 1'b1;
        stallD = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= PgActive;
      cntQ   <= '0;
      pgQ    <= 1'b0;
      gateQ  <= 1'b0;
      isoQ   <= 1'b0;
      stallQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      pgQ    <= pgD;
      gateQ  <= gateD;
      isoQ   <= isoD;
      stallQ <= stallD;
    end
  end

  assign outPG        = {NumPorts{pgQ}};
  assign gateEn       = gateQ;
  assign isoEn        = isoQ;
  assign injectStall  = stallQ;
  assign pgCountValue = cntQ;

  for (genvar d = 0; d < NumPorts; d++) begin : gWakeReq
    pg_wake_req uWakeReq (
      .clk      (clk),
      .reset    (reset),
      .routeWant(routeWant[d]),
      .inPG     (inPG[d]),
      .outWU    (outWU[d])
    );
  end

endmodule

// File: tb/tb_router_pg_ctrl.sv
// Self-checking bench for router_pg_ctrl: directed power-gating scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_router_pg_ctrl;

  localparam int IdleThresh = 16;
  localparam int DrainCyc   = 3;
  localparam int WakeLat    = 4;
  localparam int CntW       = 8;
  localparam int CntMax     = (1 << CntW) - 1;

  localparam int MActive = 0;
  localparam int MDrain  = 1;
  localparam int MSleep  = 2;
  localparam int MWake   = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [3:0]      inValid, inPG, inWU, routeWant;
  logic            injectReq;
  logic [3:0]      outPG, outWU;
  logic            gateEn, isoEn, injectStall;
  logic [CntW-1:0] pgCountValue;

  router_pg_ctrl #(
    .IDLE_THRESH(IdleThresh),
    .DRAIN_CYC  (DrainCyc),
    .WAKE_LAT   (WakeLat),
    .CNT_W      (CntW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inValid     (inValid),
    .injectReq   (injectReq),
    .inPG        (inPG),
    .inWU        (inWU),
    .routeWant   (routeWant),
    .outPG       (outPG),
    .outWU       (outWU),
    .gateEn      (gateEn),
    .isoEn       (isoEn),
    .injectStall (injectStall),
    .pgCountValue(pgCountValue)
  );

  always #5 clk = ~clk;

  // Behavioural model: operating mode, phase counter, expected registered outputs.
  int   mode, cnt;
  logic [3:0] wuM;
  logic pgE, gateE, isoE, stallE;
  int   nVec, nChk, nMis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mode   = MActive;
    cnt    = 0;
    wuM    = 4'h0;
    pgE    = 1'b0;
    gateE  = 1'b0;
    isoE   = 1'b0;
    stallE = 1'b0;
  endtask

  function automatic int bump(input int v);
    return (v < CntMax) ? v + 1 : CntMax;
  endfunction

  task automatic modelStep();
    int   old;
    logic wake, busy;
    old  = mode;
    wake = injectReq || (inWU != 4'h0);
    busy = wake || (inValid != 4'h0);
    case (old)
      MActive: begin
        if (busy) cnt = 0;
        else if (cnt == IdleThresh - 1) begin mode = MDrain; cnt = 0; end
        else cnt = bump(cnt);
      end
      MDrain: begin
        if (wake) begin mode = MActive; cnt = 0; end
        else if (inValid != 4'h0) cnt = 0;
        else if (cnt == DrainCyc - 1) begin mode = MSleep; cnt = 0; end
        else cnt = bump(cnt);
      end
      MSleep: begin
        cnt = 0;
        if (wake) mode = MWake;
      end
      default: begin
        if (cnt == WakeLat - 1) begin mode = MActive; cnt = 0; end
        else cnt = bump(cnt);
      end
    endcase
    // Outputs visible after this edge reflect the mode held before it.
    pgE    = (old != MActive);
    stallE = (old != MActive);
    gateE  = (old == MSleep);
    isoE   = (old == MSleep) || (old == MWake);
    for (int d = 0; d < 4; d++) begin
      if (routeWant[d] && inPG[d]) wuM[d] = 1'b1;
      else if (!inPG[d]) wuM[d] = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
    nVec++;
    check("outPG", 32'(outPG), 32'({4{pgE}}));
    check("outWU", 32'(outWU), 32'(wuM));
    check("gateEn", 32'(gateEn), 32'(gateE));
    check("isoEn", 32'(isoEn), 32'(isoE));
    check("injectStall", 32'(injectStall), 32'(stallE));
    check("pgCountValue", 32'(pgCountValue), 32'(cnt));
  endtask

  task automatic idleInputs();
    inValid   = 4'h0;
    injectReq = 1'b0;
    inPG      = 4'h0;
    inWU      = 4'h0;
    routeWant = 4'h0;
  endtask

  // Called just after an active edge; drops reset mid-cycle.
  task automatic resetPulse(input string tag);
    #3;
    reset = 1'b0;
    #1;
    check({tag, "_gateEn"}, 32'(gateEn), 32'h0);
    check({tag, "_isoEn"}, 32'(isoEn), 32'h0);
    check({tag, "_outPG"}, 32'(outPG), 32'h0);
    check({tag, "_outWU"}, 32'(outWU), 32'h0);
    check({tag, "_cnt"}, 32'(pgCountValue), 32'h0);
    modelReset();
    repeat (2) @(posedge clk);
    #4;
    reset = 1'b1;
  endtask

  task automatic busyCycle();
    injectReq = 1'b1;
    cycle();
    injectReq = 1'b0;
  endtask

  initial begin
    int rate;
    nVec = 0; nChk = 0; nMis = 0;
    idleInputs();
    modelReset();
    #12;
    check("rst_outPG", 32'(outPG), 32'h0);
    check("rst_gateEn", 32'(gateEn), 32'h0);
    check("rst_stall", 32'(injectStall), 32'h0);
    check("rst_cnt", 32'(pgCountValue), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // T1: idle entry straight out of reset
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (i == 15) check("t1_cnt15", 32'(pgCountValue), 32'd15);
      if (i == 16) check("t1_pg_lag", 32'(outPG), 32'h0);
      if (i == 17) check("t1_pg_drain", 32'(outPG), 32'hF);
      if (i == 17) check("t1_stall", 32'(injectStall), 32'h1);
      if (i == 19) check("t1_gate_lag", 32'(gateEn), 32'h0);
      if (i == 20) check("t1_gate", 32'(gateEn), 32'h1);
      if (i == 20) check("t1_iso", 32'(isoEn), 32'h1);
    end

    // T3: single-cycle neighbour wake from sleep
    inWU = 4'b0001;
    cycle();
    inWU = 4'h0;
    check("t3_gate_hold", 32'(gateEn), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (i == 1) check("t3_gate_off", 32'(gateEn), 32'h0);
      if (i == 1) check("t3_iso_on", 32'(isoEn), 32'h1);
      if (i == 4) check("t3_iso_4", 32'(isoEn), 32'h1);
      if (i == 5) check("t3_iso_off", 32'(isoEn), 32'h0);
      if (i == 5) check("t3_pg_off", 32'(outPG), 32'h0);
      if (i == 5) check("t3_stall_off", 32'(injectStall), 32'h0);
    end

    // T2: flit arriving on the second drain cycle restarts the drain count
    busyCycle();
    for (int i = 1; i <= 22; i++) begin
      cycle();
      if (i == 17) inValid = 4'b0100;
      if (i == 18) begin
        inValid = 4'h0;
        check("t2_restart", 32'(pgCountValue), 32'h0);
      end
      if (i == 21) check("t2_gate_late", 32'(gateEn), 32'h0);
      if (i == 22) check("t2_gate", 32'(gateEn), 32'h1);
    end

    // T4: injection request coinciding with the drain completion aborts sleep
    inWU = 4'b1000;
    cycle();
    inWU = 4'h0;
    repeat (5) cycle();
    busyCycle();
    for (int i = 1; i <= 21; i++) begin
      cycle();
      if (i == 18) injectReq = 1'b1;
      if (i == 19) begin
        injectReq = 1'b0;
        check("t4_cnt", 32'(pgCountValue), 32'h0);
        check("t4_stall_lag", 32'(injectStall), 32'h1);
      end
      if (i == 20) check("t4_stall", 32'(injectStall), 32'h0);
      if (i == 21) check("t4_no_sleep", 32'(gateEn), 32'h0);
    end

    // T5: wake request toward a gated neighbour
    inPG = 4'b0011;
    routeWant = 4'b0010;
    cycle();
    check("t5_set", 32'(outWU), 32'b0010);
    routeWant = 4'h0;
    cycle();
    check("t5_hold", 32'(outWU), 32'b0010);
    inPG = 4'b0001;
    cycle();
    check("t5_clear", 32'(outWU), 32'h0);
    inPG = 4'h0;
    cycle();

    // T6: asynchronous reset while asleep
    busyCycle();
    inPG = 4'hF;
    routeWant = 4'b0001;
    repeat (22) cycle();
    check("t6_gate_pre", 32'(gateEn), 32'h1);
    check("t6_wu_pre", 32'(outWU), 32'b0001);
    resetPulse("t6");
    idleInputs();

    // Randomized traffic with varying activity rate
    rate = 5;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) rate = $urandom_range(0, 20);
      inValid   = ($urandom_range(0, 99) < rate) ? 4'($urandom_range(1, 15)) : 4'h0;
      injectReq = ($urandom_range(0, 199) < rate);
      inWU      = ($urandom_range(0, 299) < rate) ? 4'($urandom_range(1, 15)) : 4'h0;
      if ($urandom_range(0, 9) == 0) inPG = 4'($urandom_range(0, 15));
      routeWant = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      cycle();
      if (c == 2000) resetPulse("rnd_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
